// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe_arst register pipeline.
package dff_pipe_pkg;

   localparam int unsigned DEF_RST_VAL = 0;

   // Width of an occupancy counter that must hold 0..depth inclusive.
   function automatic int unsigned CNT_W(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_arst_if.sv
// Streaming handshake bundle for dff_pipe_arst: upstream push, downstream pop, flush and occupancy.
interface dff_pipe_arst_if
   import dff_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = CNT_W(DEPTH);

   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CW-1:0]    count;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );

endinterface

// File: rtl/dff_pipe_arst_pipe_stage.sv
// One pipeline register stage: valid bit plus data word, data only loaded under a valid word.
module pipe_stage
   import dff_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             ld,
   input  logic             prev_vld,
   input  logic [WIDTH-1:0] prev_data,
   output logic             vld,
   output logic [WIDTH-1:0] data
);

   logic             r_vld;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= 1'b0;
         r_data <= RST_VAL;
      end else if (flush) begin
         r_vld  <= 1'b0;
         r_data <= RST_VAL;
      end else if (ld) begin
         r_vld <= prev_vld;
         // Bubbles leave the data register untouched.
         if (prev_vld) r_data <= prev_data;
      end
   end

   assign vld  = r_vld;
   assign data = r_data;

endmodule

// File: rtl/dff_pipe_arst.sv
// WIDTH x DEPTH async-reset register pipeline with valid/ready backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe_arst
   import dff_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
   input logic            clk,
   input logic            rst_n,
   dff_pipe_arst_if.slave bus
);

   localparam int unsigned CW = CNT_W(DEPTH);

   if (DEPTH < 1) begin : g_bad_depth
      $error("dff_pipe_arst: DEPTH must be >= 1");
   end

   logic [DEPTH:0]   w_rdy;
   logic [DEPTH-1:0] w_vld;
   logic [WIDTH-1:0] w_data [DEPTH];
   logic             w_in_fire;
   logic             w_out_fire;
   logic [CW-1:0]    r_count;

   // A stage may load when it is empty or its successor is loading too.
   assign w_rdy[DEPTH] = bus.out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_prev_vld;
      logic [WIDTH-1:0] w_prev_data;

      if (i == 0) begin : g_first
         assign w_prev_vld  = bus.in_valid;
         assign w_prev_data = bus.in_data;
      end else begin : g_next
         assign w_prev_vld  = w_vld[i-1];
         assign w_prev_data = w_data[i-1];
      end

      assign w_rdy[i] = ~w_vld[i] | w_rdy[i+1];

      pipe_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (bus.flush),
         .ld        (w_rdy[i]),
         .prev_vld  (w_prev_vld),
         .prev_data (w_prev_data),
         .vld       (w_vld[i]),
         .data      (w_data[i])
      );
   end

   assign bus.in_ready  = w_rdy[0] & ~bus.flush & rst_n;
   assign bus.out_valid = w_vld[DEPTH-1] & ~bus.flush;
   assign bus.out_data  = w_data[DEPTH-1];

   assign w_in_fire  = bus.in_valid & bus.in_ready;
   assign w_out_fire = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (bus.flush) begin
         r_count <= '0;
      end else if (w_in_fire && !w_out_fire) begin
         r_count <= r_count + CW'(1);
      end else if (w_out_fire && !w_in_fire) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign bus.count = r_count;

endmodule

// File: tb/tb_dff_pipe_arst.sv
// Scoreboard bench for dff_pipe_arst (WIDTH=8, DEPTH=4, RST_VAL=0x5A).
module tb_dff_pipe_arst;

   localparam int unsigned W   = 8;
   localparam int unsigned D   = 4;
   localparam logic [W-1:0] RV = 8'h5A;

   logic clk;
   logic rst_n;

   dff_pipe_arst_if #(.WIDTH(W), .DEPTH(D)) bus ();

   dff_pipe_arst #(
      .WIDTH   (W),
      .DEPTH   (D),
      .RST_VAL (RV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q [$];
   int           m_count = 0;
   int           max_count = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
      $fatal(1);
   end

   // Scoreboard/monitor: samples 2 time units before each rising edge.
   always @(negedge clk) begin
      logic         in_fire;
      logic         out_fire;
      logic [W-1:0] e;
      logic         exp_rdy;
      #3;
      if (!rst_n) begin
         exp_q.delete();
         m_count = 0;
      end else begin
         n_tests++;
         if (bus.count !== m_count[2:0]) begin
            n_fail++;
            $display("FAIL mon_count got=%0d expected=%0d", bus.count, m_count);
         end
         exp_rdy = !bus.flush && (m_count < D || bus.out_ready);
         n_tests++;
         if (bus.in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL mon_in_ready got=%b expected=%b", bus.in_ready, exp_rdy);
         end
         in_fire  = bus.in_valid && bus.in_ready;
         out_fire = bus.out_valid && bus.out_ready;
         if (out_fire) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_pop got=%h expected=<empty queue>", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin
                  n_fail++;
                  $display("FAIL sb_data got=%h expected=%h", bus.out_data, e);
               end
            end
         end
         if (in_fire) exp_q.push_back(bus.in_data);
         m_count = m_count + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
         if (m_count > max_count) max_count = m_count;
         if (bus.flush) begin
            exp_q.delete();
            m_count = 0;
         end
      end
   end

   // Apply inputs right after a falling edge, then let one rising edge pass.
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = ordy;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((bus.count !== 0 || bus.out_valid !== 1'b0) && n < 20) begin
         cyc(1'b0, 8'h00, 1'b1);
         n++;
      end
      n_tests++;
      if (n >= 20) begin
         n_fail++;
         $display("FAIL drain_timeout got=count%0d expected=count0", bus.count);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_leftover got=%0d expected=0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.count !== 3'd0 || bus.out_data !== RV) begin
         n_fail++;
         $display("FAIL reset_state got=v%b r%b c%0d d%h expected=v0 r0 c0 d%h",
                  bus.out_valid, bus.in_ready, bus.count, bus.out_data, RV);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      cyc(1'b1, 8'hC1, 1'b0);
      cyc(1'b1, 8'hC2, 1'b0);
      cyc(1'b1, 8'hC3, 1'b0);
      bus.in_valid = 1'b0;
      n_tests++;
      if (bus.count !== 3'd3) begin
         n_fail++;
         $display("FAIL rstmid_prefill got=%0d expected=3", bus.count);
      end
      bus.in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.count !== 3'd0 || bus.out_data !== RV) begin
         n_fail++;
         $display("FAIL rstmid_async got=v%b r%b c%0d d%h expected=v0 r0 c0 d%h",
                  bus.out_valid, bus.in_ready, bus.count, bus.out_data, RV);
      end
      exp_q.delete();
      m_count = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_streaming();
      max_count = 0;
      cyc(1'b1, 8'h11, 1'b1);
      cyc(1'b1, 8'h22, 1'b1);
      cyc(1'b1, 8'h33, 1'b1);
      bus.in_valid = 1'b0;
      n_tests++;
      if (bus.count !== 3'd3 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_fill got=c%0d v%b expected=c3 v0", bus.count, bus.out_valid);
      end
      cyc(1'b0, 8'h00, 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
         n_fail++;
         $display("FAIL stream_latency got=v%b d%h expected=v1 d11", bus.out_valid, bus.out_data);
      end
      cyc(1'b0, 8'h00, 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22) begin
         n_fail++;
         $display("FAIL stream_b2b got=v%b d%h expected=v1 d22", bus.out_valid, bus.out_data);
      end
      drain();
      n_tests++;
      if (max_count != 3) begin
         n_fail++;
         $display("FAIL stream_peak got=%0d expected=3", max_count);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] w [5];
      w[0] = 8'hA1; w[1] = 8'hA2; w[2] = 8'hA3; w[3] = 8'hA4; w[4] = 8'hA5;
      for (int i = 0; i < 4; i++) cyc(1'b1, w[i], 1'b0);
      bus.in_data = w[4];
      #1;
      n_tests++;
      if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_full got=c%0d r%b expected=c4 r0", bus.count, bus.in_ready);
      end
      cyc(1'b1, w[4], 1'b0);
      n_tests++;
      if (bus.count !== 3'd4 || bus.out_data !== w[0]) begin
         n_fail++;
         $display("FAIL bp_hold got=c%0d d%h expected=c4 d%h", bus.count, bus.out_data, w[0]);
      end
      bus.out_ready = 1'b1;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready got=%b expected=1", bus.in_ready);
      end
      @(negedge clk);
      n_tests++;
      if (bus.count !== 3'd4 || bus.out_data !== w[1]) begin
         n_fail++;
         $display("FAIL bp_swap got=c%0d d%h expected=c4 d%h", bus.count, bus.out_data, w[1]);
      end
      bus.in_valid = 1'b0;
      drain();
   endtask

   task automatic test_bubble();
      cyc(1'b1, 8'hB0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'hB1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
      n_tests++;
      if (bus.count !== 3'd2 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hB0) begin
         n_fail++;
         $display("FAIL bubble_hold got=c%0d v%b d%h expected=c2 v1 dB0",
                  bus.count, bus.out_valid, bus.out_data);
      end
      cyc(1'b0, 8'h00, 1'b1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB1) begin
         n_fail++;
         $display("FAIL bubble_nogap got=v%b d%h expected=v1 dB1", bus.out_valid, bus.out_data);
      end
      drain();
   endtask

   task automatic test_flush();
      int n = 0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'hF0 + 8'(i), 1'b0);
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hEE;
      bus.out_ready = 1'b1;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_gate got=r%b v%b expected=r0 v0", bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      n_tests++;
      if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data !== RV) begin
         n_fail++;
         $display("FAIL flush_clear got=c%0d v%b d%h expected=c0 v0 d%h",
                  bus.count, bus.out_valid, bus.out_data, RV);
      end
      @(negedge clk);
      cyc(1'b1, 8'h77, 1'b1);
      bus.in_valid = 1'b0;
      while (bus.out_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (n != D - 1 || bus.out_data !== 8'h77) begin
         n_fail++;
         $display("FAIL flush_relatency got=%0d cycles d%h expected=%0d cycles d77", n, bus.out_data, D - 1);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 8'h50 + 8'(i), 1'b1);
         n_tests++;
         if (bus.count !== 3'd4) begin
            n_fail++;
            $display("FAIL b2b_count cyc%0d got=%0d expected=4", i, bus.count);
         end
      end
      bus.in_valid = 1'b0;
      drain();
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_reset_midstream();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_flush();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
